// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register-file write port arbiter: pipeline WB vs queued MDU results
// Pipeline writes always win; MDU results drain from a FIFO into idle slots and a scoreboard tracks pending MDU destinations.
module rf_wb_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we_i,
  input  logic [4:0]  pipe_addr_i,
  input  logic [31:0] pipe_data_i,
  input  logic        mdu_valid_i,
  output logic        mdu_ready_o,
  input  logic [4:0]  mdu_addr_i,
  input  logic [31:0] mdu_data_i,
  input  logic        iss_valid_i,
  input  logic [4:0]  iss_addr_i,
  output logic        iss_ready_o,
  input  logic [4:0]  chk_rs_i,
  input  logic [4:0]  chk_rt_i,
  input  logic [4:0]  chk_rd_i,
  output logic        haz_rs_o,
  output logic        haz_rt_o,
  output logic        haz_rd_o,
  output logic        wb_stall_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic        rf_src_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    addr_mem [FIFO_DEPTH];
  logic [31:0]   data_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   pending_q, pending_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          wb_stall_q, wb_stall_d;
  logic          rf_we_q, rf_we_d;
  logic [4:0]    rf_waddr_q, rf_waddr_d;
  logic [31:0]   rf_wdata_q, rf_wdata_d;
  logic          rf_src_q, rf_src_d;
  logic          full, empty, push, pop;

  assign full  = (cnt_q == CW'(FIFO_DEPTH));
  assign empty = (cnt_q == '0);
  assign push  = mdu_valid_i && !full;
  assign pop   = !pipe_we_i && !empty;

  assign mdu_ready_o = !full;
  assign iss_ready_o = !pending_q[iss_addr_i];
  assign haz_rs_o    = pending_q[chk_rs_i] && (chk_rs_i != 5'd0);
  assign haz_rt_o    = pending_q[chk_rt_i] && (chk_rt_i != 5'd0);
  assign haz_rd_o    = pending_q[chk_rd_i] && (chk_rd_i != 5'd0);
  assign wb_stall_o  = wb_stall_q;
  assign rf_we_o     = rf_we_q;
  assign rf_waddr_o  = rf_waddr_q;
  assign rf_wdata_o  = rf_wdata_q;
  assign rf_src_o    = rf_src_q;

  always_comb begin
    cnt_d = cnt_q + CW'(push) - CW'(pop);

    if (empty || pop)
      starve_d = '0;
    else if (starve_q == SW'(STARVE_LIMIT))
      starve_d = starve_q;
    else
      starve_d = starve_q + SW'(1);

    // Stall is registered from next state so it tracks the current queue condition.
    wb_stall_d = (starve_d == SW'(STARVE_LIMIT)) || (cnt_d == CW'(FIFO_DEPTH));

    rf_we_d    = 1'b0;
    rf_waddr_d = 5'd0;
    rf_wdata_d = 32'd0;
    rf_src_d   = 1'b0;
    if (pipe_we_i) begin
      rf_we_d    = (pipe_addr_i != 5'd0);
      rf_waddr_d = pipe_addr_i;
      rf_wdata_d = pipe_data_i;
    end else if (pop) begin
      rf_we_d    = (addr_mem[rd_ptr_q] != 5'd0);
      rf_waddr_d = addr_mem[rd_ptr_q];
      rf_wdata_d = data_mem[rd_ptr_q];
      rf_src_d   = 1'b1;
    end

    pending_d = pending_q;
    if (rf_we_q && rf_src_q)
      pending_d[rf_waddr_q] = 1'b0;
    if (iss_valid_i && iss_ready_o && (iss_addr_i != 5'd0))
      pending_d[iss_addr_i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= mdu_addr_i;
      data_mem[wr_ptr_q] <= mdu_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      pending_q  <= '0;
      starve_q   <= '0;
      wb_stall_q <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= 32'd0;
      rf_src_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      starve_q   <= starve_d;
      wb_stall_q <= wb_stall_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      rf_src_q   <= rf_src_d;
    end
  end
endmodule
